level_sensor_filter: RTL and testbench
======================================

Name: level_sensor_filter

Overview:
- Conditioning stage directly upstream of the pump controller. It takes the three raw float-switch contacts: underground low level, overhead high level and overhead low level.
- Each contact is synchronised and debounced. The stage then produces the clean ug_ll / uh_hl / uh_ll levels that the controller consumes.
- It also checks the overhead pair for plausibility. A persistent impossible combination latches a sensor fault, and the fault forces the pump-safe condition (ug_ll = 0).

Parameters:
- DEBOUNCE_CYCLES, 16, number of consecutive cycles a synchronised input must differ from its debounced value before the debounced value flips. Minimum 2.
- FAULT_CYCLES, 64, number of consecutive cycles the implausible overhead combination must persist before sensor_fault latches. Minimum 1.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- ug_ll_raw  input  1  raw underground low-level switch (1 = water present); asynchronous to clk.
- uh_hl_raw  input  1  raw overhead high-level switch (1 = water at/above high mark); asynchronous.
- uh_ll_raw  input  1  raw overhead low-level switch (1 = water at/above low mark); asynchronous.
- fault_clr  input  1  synchronous request to clear a latched sensor_fault.
- ug_ll  output  1  filtered underground level to controller; forced 0 while sensor_fault=1.
- uh_hl  output  1  debounced overhead high level to controller.
- uh_ll  output  1  debounced overhead low level to controller.
- uh_level  output  2  indicator code: 0 empty, 1 mid, 2 full, 3 invalid.
- sensor_fault  output  1  latched plausibility fault.

Behaviour:
- Reset (async assert, sync use after deassert) clears all of the following to 0:
  - sync flops, debounced values, debounce counters, fault counter;
  - outputs ug_ll, uh_hl, uh_ll and sensor_fault;
  - uh_level therefore resets to 0.
- Reset mid-debounce or mid-fault-count discards progress. Assertion is immediate, no clock needed.
- Per channel, identical and independent:
  - A 2-flop synchroniser produces s.
  - The channel has a debounced value db and a counter cnt, with width clog2(DEBOUNCE_CYCLES).
  - Each edge:
    - if s == db: cnt <= 0;
    - else if cnt == DEBOUNCE_CYCLES-1: db <= s, cnt <= 0;
    - else: cnt <= cnt+1.
  - Latency: a raw change held stable before edge 0 appears on db after edge DEBOUNCE_CYCLES+1 (DEBOUNCE_CYCLES+2 edges total).
  - A pulse seen on s for fewer than DEBOUNCE_CYCLES consecutive cycles never changes db. Any return of s to db restarts the count from 0.
- Outputs from db:
  - uh_hl = db_hl and uh_ll = db_ll, registered, with no extra delay.
  - ug_ll = db_ug & ~sensor_fault.
  - uh_level is combinational from {db_hl, db_ll}: 00→0, 01→1, 11→2, 10→3.
- Plausibility:
  - imp = db_hl & ~db_ll.
  - Fault counter fc saturates, width clog2(FAULT_CYCLES+1).
  - Each edge: if !imp, fc <= 0; else if fc != FAULT_CYCLES, fc <= fc+1.
  - sensor_fault sets on the edge where fc reaches FAULT_CYCLES, i.e. after FAULT_CYCLES consecutive imp cycles.
  - Once set, sensor_fault stays 1. Loss of imp alone does not clear it.
- Fault clear:
  - fault_clr=1 on an edge clears sensor_fault and fc only if imp==0 on that edge. Otherwise it is ignored.
  - A set condition and fault_clr on the same edge: set wins.
  - fault_clr while no fault is present has no effect.
- Forcing:
  - ug_ll drops to 0 in the same cycle sensor_fault rises.
  - ug_ll restores to db_ug in the cycle after a successful clear.
  - uh_hl, uh_ll and uh_level are never masked, so the indicator shows 3 during the fault.
- Simultaneous changes on several raw inputs are handled independently per channel. There is no cross-channel ordering guarantee.

Test Plan:
(DEBOUNCE_CYCLES=4, FAULT_CYCLES=8)
- Reset then idle:
  - stimulus: rst pulsed mid-cycle with raw inputs all 1;
  - response: all outputs 0 immediately;
  - then after rst drops: ug_ll, uh_hl and uh_ll rise 6 edges later, and uh_level goes 0 → 2 (via 3 or 1 allowed only if channel edges differ; the bench drives them together, so direct 0 → 2).
- Glitch rejection:
  - stimulus: ug_ll=1 stable, then ug_ll_raw low for 3 cycles, then high;
  - response: ug_ll stays 1 throughout;
  - then low for 4 cycles: ug_ll falls exactly 6 edges after the first low edge.
- Fill sequence:
  - stimulus: uh_ll_raw 0→1, then 20 cycles later uh_hl_raw 0→1;
  - response: uh_level goes 0 → 1 → 2, each step 6 edges after its raw change;
  - sensor_fault stays 0.
- Fault latch:
  - stimulus: hold uh_hl_raw=1, uh_ll_raw=0 with ug_ll_raw=1;
  - response: uh_level=3 once debounced, sensor_fault=1 and ug_ll=0 after 8 further edges;
  - a 7-cycle imp window gives no fault.
- Clear rules:
  - fault_clr while imp is still present → sensor_fault stays 1;
  - restore uh_ll_raw=1, wait for debounce, pulse fault_clr → sensor_fault=0 and ug_ll=1 next cycle;
  - imp reaching the FAULT_CYCLES count on the same edge as fault_clr → fault sets.

Source files
------------

// File: rtl/level_sensor_filter_if.sv
// level_sensor_filter_if
// ----------------------
// Bundles the signals between the float-switch conditioning stage and the
// rest of the system. The raw contacts and the fault-clear request go into
// the filter. The clean levels, the indicator code and the fault flag come out.
//
// Signals:
//   ug_ll_raw    raw underground low-level switch (1 = water present), async
//   uh_hl_raw    raw overhead high-level switch (1 = at/above high mark), async
//   uh_ll_raw    raw overhead low-level switch (1 = at/above low mark), async
//   fault_clr    synchronous request to clear a latched sensor fault
//   ug_ll        filtered underground level, forced 0 while sensor_fault = 1
//   uh_hl        debounced overhead high level
//   uh_ll        debounced overhead low level
//   uh_level     indicator code: 0 empty, 1 mid, 2 full, 3 invalid
//   sensor_fault latched plausibility fault
//
// Modports:
//   slave  - the filter itself
//   master - whatever drives the raw contacts and consumes the results

interface level_sensor_filter_if;
   logic       ug_ll_raw;
   logic       uh_hl_raw;
   logic       uh_ll_raw;
   logic       fault_clr;
   logic       ug_ll;
   logic       uh_hl;
   logic       uh_ll;
   logic [1:0] uh_level;
   logic       sensor_fault;

   modport slave (
      input  ug_ll_raw,
      input  uh_hl_raw,
      input  uh_ll_raw,
      input  fault_clr,
      output ug_ll,
      output uh_hl,
      output uh_ll,
      output uh_level,
      output sensor_fault
   );

   modport master (
      output ug_ll_raw,
      output uh_hl_raw,
      output uh_ll_raw,
      output fault_clr,
      input  ug_ll,
      input  uh_hl,
      input  uh_ll,
      input  uh_level,
      input  sensor_fault
   );
endinterface

// File: rtl/level_sensor_filter.sv
// level_sensor_filter
// -------------------
// Conditioning stage that sits in front of the pump controller. It takes the
// three raw float-switch contacts and gives each one a 2-flop synchroniser
// and a debouncer. The stage then checks the overhead pair for plausibility.
// If the high switch stays wet while the low switch reads dry for long
// enough, a sensor fault latches. The fault holds the underground level at 0,
// so the controller sees the pump-safe condition.
//
// Ports:
//   clk       system clock, everything on the rising edge
//   rst       asynchronous active-high reset
//   sensorBus level_sensor_filter_if.slave (raw contacts, fault_clr, results)
//
// Parameters:
//   DEBOUNCE_CYCLES  consecutive disagreeing cycles before a debounced value
//                    flips (must be at least 2)
//   FAULT_CYCLES     consecutive implausible cycles before the fault latches
//                    (must be at least 1)

module level_sensor_filter #(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int FAULT_CYCLES    = 64
) (
   input logic                  clk,
   input logic                  rst,
   level_sensor_filter_if.slave sensorBus
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
   localparam int FC_W  = $clog2(FAULT_CYCLES + 1);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [FC_W-1:0]  FC_MAX   = FC_W'(FAULT_CYCLES);
   localparam logic [FC_W-1:0]  FC_LAST  = FC_W'(FAULT_CYCLES - 1);

   localparam int CH_UG = 0;
   localparam int CH_HL = 1;
   localparam int CH_LL = 2;

   logic [2:0]       rawVec;
   logic [2:0]       syncA_q;
   logic [2:0]       syncB_q;
   logic [2:0]       db_q;
   logic [2:0]       db_d;
   logic [CNT_W-1:0] cnt_q [3];
   logic [CNT_W-1:0] cnt_d [3];
   logic [FC_W-1:0]  fcnt_q;
   logic [FC_W-1:0]  fcnt_d;
   logic             fault_q;
   logic             fault_d;
   logic             imp;
   logic             setFault;

   assign rawVec = {sensorBus.uh_ll_raw, sensorBus.uh_hl_raw, sensorBus.ug_ll_raw};

   // Two-stage synchroniser for all three contacts. The contacts are
   // asynchronous to clk, so only syncB_q is used by the logic below.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         syncA_q <= '0;
         syncB_q <= '0;
      end else begin
         syncA_q <= rawVec;
         syncB_q <= syncA_q;
      end
   end

   // Debounce next-state, with each channel handled independently. The
   // counter tracks how long the synchronised input has disagreed with the
   // debounced value. Any agreement sends the count back to zero, so only an
   // unbroken run of DEBOUNCE_CYCLES disagreeing cycles flips the value.
   always_comb begin
      db_d = db_q;
      for (int ch = 0; ch < 3; ch++) begin
         cnt_d[ch] = cnt_q[ch];
         if (syncB_q[ch] == db_q[ch]) begin
            cnt_d[ch] = '0;
         end else if (cnt_q[ch] == CNT_LAST) begin
            db_d[ch]  = syncB_q[ch];
            cnt_d[ch] = '0;
         end else begin
            cnt_d[ch] = cnt_q[ch] + CNT_W'(1);
         end
      end
   end

   // High switch wet while the low switch is dry cannot happen with a healthy
   // tank. This is judged on the debounced values, so switch bounce alone
   // never counts toward a fault.
   assign imp      = db_q[CH_HL] & ~db_q[CH_LL];
   assign setFault = imp && (fcnt_q == FC_LAST);

   // Fault counter and latch next-state. The counter saturates, so a fault
   // that is held with imp still present does not wrap around. A clear is
   // honoured only once the overhead pair reads plausible again. Setting
   // needs imp and clearing needs its absence, so a set on the same edge as
   // a clear request always wins.
   always_comb begin
      fcnt_d  = fcnt_q;
      fault_d = fault_q;
      if (!imp) begin
         fcnt_d = '0;
      end else if (fcnt_q != FC_MAX) begin
         fcnt_d = fcnt_q + FC_W'(1);
      end
      if (setFault) begin
         fault_d = 1'b1;
      end else if (sensorBus.fault_clr && !imp) begin
         fault_d = 1'b0;
         fcnt_d  = '0;
      end
   end

   // State registers for the debouncers and the fault logic. Reset discards
   // any partly finished debounce or fault count.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         db_q    <= '0;
         fcnt_q  <= '0;
         fault_q <= 1'b0;
         for (int ch = 0; ch < 3; ch++) begin
            cnt_q[ch] <= '0;
         end
      end else begin
         db_q    <= db_d;
         fcnt_q  <= fcnt_d;
         fault_q <= fault_d;
         for (int ch = 0; ch < 3; ch++) begin
            cnt_q[ch] <= cnt_d[ch];
         end
      end
   end

   // The underground level is masked by the fault, so it drops in the same
   // cycle the fault rises. The overhead levels are never masked, so the
   // indicator still shows the invalid code while the fault is active.
   assign sensorBus.ug_ll        = db_q[CH_UG] & ~fault_q;
   assign sensorBus.uh_hl        = db_q[CH_HL];
   assign sensorBus.uh_ll        = db_q[CH_LL];
   assign sensorBus.sensor_fault = fault_q;

   // Indicator code from the {high, low} debounced pair.
   always_comb begin
      sensorBus.uh_level = 2'd0;
      case ({db_q[CH_HL], db_q[CH_LL]})
         2'b00:   sensorBus.uh_level = 2'd0;
         2'b01:   sensorBus.uh_level = 2'd1;
         2'b11:   sensorBus.uh_level = 2'd2;
         default: sensorBus.uh_level = 2'd3;
      endcase
   end

endmodule

// File: tb/tb_level_sensor_filter.sv
// tb_level_sensor_filter
// ----------------------
// Directed bench for level_sensor_filter with DEBOUNCE_CYCLES = 4 and
// FAULT_CYCLES = 8. Inputs change 1 time unit after a rising edge, and
// outputs are sampled 1 time unit after a rising edge. A raw change made
// before edge 0 therefore shows up on the debounced outputs after edge 5,
// which is the sixth edge.

module tb_level_sensor_filter;

   logic clk;
   logic rst;
   int   vectors;
   int   miscompares;

   level_sensor_filter_if bus ();

   level_sensor_filter #(
      .DEBOUNCE_CYCLES(4),
      .FAULT_CYCLES   (8)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .sensorBus(bus)
   );

   // Free-running 10-unit clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive the raw contacts and the clear request.
   task automatic applyStimulus(input logic ug, input logic hl, input logic ll, input logic clr);
      bus.ug_ll_raw = ug;
      bus.uh_hl_raw = hl;
      bus.uh_ll_raw = ll;
      bus.fault_clr = clr;
   endtask

   // Advance n rising edges, then settle 1 unit past the last one.
   task automatic waitEdges(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // One comparison: counts it and reports a miscompare.
   task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
      vectors++;
      assert (observed === expected)
      else begin
         miscompares++;
         $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
      end
   endtask

   // Compare every output against the hand-computed expectation.
   task automatic checkAll(input string tag, input logic ug, input logic hl, input logic ll,
                           input logic [1:0] lvl, input logic flt);
      checkOutput({tag, ".ug_ll"}, {7'd0, bus.ug_ll}, {7'd0, ug});
      checkOutput({tag, ".uh_hl"}, {7'd0, bus.uh_hl}, {7'd0, hl});
      checkOutput({tag, ".uh_ll"}, {7'd0, bus.uh_ll}, {7'd0, ll});
      checkOutput({tag, ".uh_level"}, {6'd0, bus.uh_level}, {6'd0, lvl});
      checkOutput({tag, ".sensor_fault"}, {7'd0, bus.sensor_fault}, {7'd0, flt});
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      rst         = 1'b1;
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);

      // Reset state while inputs are all 1.
      waitEdges(3);
      checkAll("reset_hold", 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);

      // Release reset: outputs rise together on the sixth edge, 0 -> 2 directly.
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         waitEdges(1);
         checkOutput("release_lvl_low", {6'd0, bus.uh_level}, 8'd0);
         checkOutput("release_ug_low", {7'd0, bus.ug_ll}, 8'd0);
      end
      waitEdges(1);
      checkAll("release_up", 1'b1, 1'b1, 1'b1, 2'd2, 1'b0);

      // A mid-cycle reset clears everything immediately, with no clock edge.
      @(negedge clk);
      rst = 1'b1;
      #1;
      checkAll("async_reset", 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
      waitEdges(2);
      @(negedge clk);
      rst = 1'b0;
      waitEdges(5);
      checkAll("rerelease_wait", 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
      waitEdges(1);
      checkAll("rerelease_up", 1'b1, 1'b1, 1'b1, 2'd2, 1'b0);

      // Glitch rejection: a 3-cycle low pulse never reaches ug_ll.
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
      waitEdges(3);
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 10; i++) begin
         waitEdges(1);
         checkOutput("glitch3_ug", {7'd0, bus.ug_ll}, 8'd1);
      end

      // A 4-cycle low pulse is accepted: ug_ll falls on the sixth edge.
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
      waitEdges(4);
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
      waitEdges(1);
      checkOutput("glitch4_ug_edge5", {7'd0, bus.ug_ll}, 8'd1);
      waitEdges(1);
      checkOutput("glitch4_ug_edge6", {7'd0, bus.ug_ll}, 8'd0);
      waitEdges(10);
      checkOutput("glitch4_ug_back", {7'd0, bus.ug_ll}, 8'd1);

      // Empty the overhead tank, then fill it: level 0 -> 1 -> 2.
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      waitEdges(10);
      checkAll("empty", 1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
      waitEdges(5);
      checkOutput("fill_mid_wait", {6'd0, bus.uh_level}, 8'd0);
      waitEdges(1);
      checkAll("fill_mid", 1'b1, 1'b0, 1'b1, 2'd1, 1'b0);
      waitEdges(14);
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
      waitEdges(5);
      checkOutput("fill_full_wait", {6'd0, bus.uh_level}, 8'd1);
      waitEdges(1);
      checkAll("fill_full", 1'b1, 1'b1, 1'b1, 2'd2, 1'b0);

      // Fault latch: high wet, low dry. Invalid after 6 edges, fault 8 edges later.
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
      waitEdges(6);
      checkAll("imp_start", 1'b1, 1'b1, 1'b0, 2'd3, 1'b0);
      waitEdges(7);
      checkAll("imp_7", 1'b1, 1'b1, 1'b0, 2'd3, 1'b0);
      waitEdges(1);
      checkAll("fault_set", 1'b0, 1'b1, 1'b0, 2'd3, 1'b1);

      // Clear request while imp still holds is ignored.
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
      waitEdges(1);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
      checkAll("clr_ignored", 1'b0, 1'b1, 1'b0, 2'd3, 1'b1);

      // Plausible again, but the fault stays until a clear request arrives.
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
      waitEdges(6);
      checkAll("plausible_held", 1'b0, 1'b1, 1'b1, 2'd2, 1'b1);
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
      waitEdges(1);
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
      checkAll("clr_ok", 1'b1, 1'b1, 1'b1, 2'd2, 1'b0);

      // A clear request with no fault present changes nothing.
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
      waitEdges(1);
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
      checkAll("clr_idle", 1'b1, 1'b1, 1'b1, 2'd2, 1'b0);

      // A 7-cycle imp window is not enough to latch a fault.
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
      waitEdges(7);
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
      checkOutput("win7_level", {6'd0, bus.uh_level}, 8'd3);
      waitEdges(6);
      checkAll("win7_end", 1'b1, 1'b1, 1'b1, 2'd2, 1'b0);
      waitEdges(3);
      checkOutput("win7_after", {7'd0, bus.sensor_fault}, 8'd0);

      // A set on the same edge as a clear request wins.
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
      waitEdges(6);
      waitEdges(7);
      checkOutput("race_pre", {7'd0, bus.sensor_fault}, 8'd0);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
      waitEdges(1);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
      checkAll("race_set_wins", 1'b0, 1'b1, 1'b0, 2'd3, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
